// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions used by both the PPU-side writer and the VGA-side reader.
package fb_pkg;
  localparam int SCREEN_W    = 256;
  localparam int SCREEN_H    = 240;
  localparam int COLOR_W     = 6;
  localparam int PIXEL_NUM_W = 16;

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

  typedef logic [PIXEL_NUM_W-1:0] pixel_num_t;
  typedef logic [COLOR_W-1:0]     color_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_SWAP = 2'd2
  } fbw_state_t;

  // Same {y, x} packing the display reader uses for its fetch address.
  function automatic pixel_num_t pixel_num(input logic [7:0] x, input logic [7:0] y);
    return {y, x};
  endfunction
endpackage

// File: rtl/raster_counter.sv
// Raster x/y position counter: clear to (0,0), restart at (1,0), advance in scan order.
module raster_counter
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       restart,
  input  logic       advance,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       last
);

  assign last = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x <= 8'd0;
      y <= 8'd0;
    end else if (restart) begin
      // Pixel (0,0) is consumed by the restarting beat itself.
      x <= 8'd1;
      y <= 8'd0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= 8'd0;
        y <= (y == Y_LAST) ? 8'd0 : y + 8'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

  a_y_in_range: assert property (@(posedge clk) disable iff (reset) y <= Y_LAST);

endmodule

// File: rtl/frame_buffer_writer.sv
// Writes the PPU pixel stream into the back bank of a double-buffered frame buffer and
// swaps banks only at the display's end-of-active-frame.
module frame_buffer_writer
  import fb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic               pix_sof,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               vga_frame_end,
  output logic               write_en,
  output logic [16:0]        write_pixel_num,
  output logic [COLOR_W-1:0] write_pixel_color,
  output logic               read_bank,
  output logic               frame_done,
  output logic               frame_error,
  output logic [1:0]         debug_state
);

  fbw_state_t state;
  logic [7:0] x, y;
  logic       last;
  logic       accept, sof_hit, data_hit, swap;

  // Handshake: a beat transfers on a cycle where pix_valid && pix_ready. pix_ready is
  // decoded from state only, so it never depends on pix_valid in the same cycle.
  assign pix_ready   = (state != WAIT_SWAP);
  assign accept      = pix_valid && pix_ready;
  assign sof_hit     = accept && pix_sof;
  assign data_hit    = accept && !pix_sof && (state == FILL);
  assign swap        = (state == WAIT_SWAP) && vga_frame_end;
  assign debug_state = state;

  raster_counter u_raster (
    .clk     (clk),
    .reset   (reset),
    .clear   (swap),
    .restart (sof_hit),
    .advance (data_hit),
    .x       (x),
    .y       (y),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      read_bank         <= 1'b0;
      write_en          <= 1'b0;
      write_pixel_num   <= 17'd0;
      write_pixel_color <= '0;
      frame_done        <= 1'b0;
      frame_error       <= 1'b0;
    end else begin
      write_en    <= sof_hit || data_hit;
      frame_done  <= 1'b0;
      frame_error <= sof_hit && (state == FILL);
      if (sof_hit || data_hit) begin
        write_pixel_num   <= {~read_bank, sof_hit ? 16'h0000 : pixel_num(x, y)};
        write_pixel_color <= pix_color;
      end
      case (state)
        IDLE: begin
          if (sof_hit) state <= FILL;
        end
        FILL: begin
          // A sof on the final position is a restart, so only data_hit can complete.
          if (data_hit && last) state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (swap) begin
            read_bank  <= ~read_bank;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Randomized bench for frame_buffer_writer against a linear pixel-index model of a frame.
module tb_frame_buffer_writer;
  import fb_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pix_valid = 1'b0;
  logic         pix_ready;
  logic         pix_sof = 1'b0;
  logic [5:0]   pix_color = 6'd0;
  logic         vga_frame_end = 1'b0;
  logic         write_en;
  logic [16:0]  write_pixel_num;
  logic [5:0]   write_pixel_color;
  logic         read_bank;
  logic         frame_done;
  logic         frame_error;
  logic [1:0]   debug_state;

  frame_buffer_writer dut (
    .clk               (clk),
    .reset             (reset),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .pix_sof           (pix_sof),
    .pix_color         (pix_color),
    .vga_frame_end     (vga_frame_end),
    .write_en          (write_en),
    .write_pixel_num   (write_pixel_num),
    .write_pixel_color (write_pixel_color),
    .read_bank         (read_bank),
    .frame_done        (frame_done),
    .frame_error       (frame_error),
    .debug_state       (debug_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard and model state: mode 0=idle, 1=filling, 2=frame complete awaiting swap.
  int          checks = 0;
  int          errors = 0;
  logic [22:0] exp_q[$];
  int          m_mode = 0;
  int          m_pos = 0;
  logic        m_rb = 1'b0;
  int          n_writes = 0;
  int          n_done = 0;
  int          n_err = 0;
  localparam int FRAME_PIX = SCREEN_W * SCREEN_H;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict, then check outputs one edge later.
  task automatic step(input logic v, input logic s, input logic [5:0] c, input logic fe,
                      output logic acc);
    logic        ex_we, ex_done, ex_err;
    logic [16:0] a;
    logic [22:0] e;
    pix_valid = v;
    pix_sof = s;
    pix_color = c;
    vga_frame_end = fe;
    check_eq("pix_ready", pix_ready, m_mode != 2);
    acc = v && (m_mode != 2);
    ex_we = 1'b0;
    ex_done = 1'b0;
    ex_err = 1'b0;
    a = 17'd0;
    if (acc && s) begin
      ex_we = 1'b1;
      ex_err = (m_mode == 1);
      a = {~m_rb, 16'h0000};
      m_pos = 1;
      m_mode = 1;
    end else if (acc && m_mode == 1) begin
      ex_we = 1'b1;
      a = {~m_rb, 8'(m_pos / SCREEN_W), 8'(m_pos % SCREEN_W)};
      m_pos++;
      if (m_pos == FRAME_PIX) m_mode = 2;
    end else if (m_mode == 2 && fe) begin
      m_rb = ~m_rb;
      ex_done = 1'b1;
      m_mode = 0;
      m_pos = 0;
    end
    if (ex_we) exp_q.push_back({a, c});
    @(posedge clk);
    #1;
    check_eq("write_en", write_en, ex_we);
    check_eq("frame_done", frame_done, ex_done);
    check_eq("frame_error", frame_error, ex_err);
    check_eq("read_bank", read_bank, m_rb);
    if (write_en) n_writes++;
    if (frame_done) n_done++;
    if (frame_error) n_err++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (write_en) check_eq("write_word", {write_pixel_num, write_pixel_color}, e);
    end
  endtask

  // Offer one beat, idling randomly (duty in percent) until it is taken.
  task automatic send_beat(input logic s, input logic [5:0] c, input logic fe, input int duty);
    logic acc;
    logic v;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 2000) begin
      v = ($urandom_range(0, 99) < duty);
      step(v, v ? s : 1'($urandom_range(0, 1)), v ? c : 6'($urandom_range(0, 63)),
           v ? fe : 1'b0, acc);
      n++;
    end
    if (!acc) check_eq("beat_timeout", acc, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_color = 6'd0;
    vga_frame_end = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    m_mode = 0;
    m_pos = 0;
    m_rb = 1'b0;
    exp_q.delete();
    check_eq("rst_state", debug_state, IDLE);
    check_eq("rst_read_bank", read_bank, 1'b0);
    check_eq("rst_pix_ready", pix_ready, 1'b1);
    check_eq("rst_write_en", write_en, 1'b0);
    check_eq("rst_pixel_num", write_pixel_num, 17'd0);
    check_eq("rst_pixel_color", write_pixel_color, 6'd0);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_frame_error", frame_error, 1'b0);
  endtask

  initial begin
    logic acc;
    do_reset(3);

    // Stray beats before the first sof are dropped.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 6'($urandom_range(0, 63)), 1'b0, acc);
    check_eq("no_write_before_sof", n_writes, 0);

    // Frame begins, restarts at beat 1000, then completes; frame_end pulses in FILL ignored.
    send_beat(1'b1, 6'd0, 1'b0, 85);
    check_eq("sof_addr", write_pixel_num, 17'h10000);
    for (int i = 1; i < 1000; i++) send_beat(1'b0, 6'(i % 64), 1'b0, 85);
    send_beat(1'b1, 6'd0, 1'b0, 85);
    check_eq("restart_addr", write_pixel_num, 17'h10000);
    check_eq("restart_err_count", n_err, 1);
    for (int i = 1; i < FRAME_PIX; i++)
      send_beat(1'b0, 6'(i % 64), (i == 20000) || (i == FRAME_PIX - 1), 85);
    check_eq("last_addr", write_pixel_num, 17'h1EFFF);
    check_eq("writes_frame1", n_writes, 1000 + FRAME_PIX);
    check_eq("no_early_swap", n_done, 0);

    // Beats are refused while waiting; the next frame_end swaps.
    for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom_range(0, 1)), 6'd9, 1'b0, acc);
    check_eq("wait_state", debug_state, WAIT_SWAP);
    step(1'b0, 1'b0, 6'd0, 1'b1, acc);
    check_eq("swap_count", n_done, 1);
    check_eq("swap_bank", read_bank, 1'b1);

    // Second frame at ~50% valid duty lands in bank 0.
    for (int i = 0; i < 3000; i++) send_beat(i == 0, 6'(i % 64), 1'b0, 50);
    check_eq("frame2_bank", write_pixel_num[16], 1'b0);
    check_eq("frame2_last_addr", write_pixel_num, 17'(2999 % 256 + (2999 / 256) * 256));

    // Reset mid-FILL, then a fresh frame starts in bank 1 again.
    do_reset(1);
    for (int i = 0; i < 21; i++) send_beat(i == 0, 6'($urandom_range(0, 63)), 1'b0, 100);
    check_eq("after_reset_addr", write_pixel_num, 17'h10014);
    check_eq("error_total", n_err, 1);
    check_eq("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
Write-side counterpart of the VGA scan-out path.
- Accepts the PPU's 256x240 pixel stream on a valid/ready handshake.
- Writes each pixel into one bank of a double-buffered frame buffer at address {y[7:0], x[7:0]}, the same packing the display reader uses.
- Swaps banks only at the display's end-of-active-frame, so scan-out never shows a partially written frame.

Parameters:
SCREEN_W, 256, pixels per line (power of two; x field is 8 bits)
SCREEN_H, 240, lines per frame
COLOR_W, 6, palette-index width of one pixel

Ports:
clk  in  1  single design clock (display pixel clock)
reset  in  1  synchronous, active-high reset
pix_valid  in  1  PPU pixel beat valid
pix_ready  out  1  writer can accept a beat
pix_sof  in  1  beat is pixel (0,0) of a new frame
pix_color  in  COLOR_W  palette index of the beat
vga_frame_end  in  1  one-cycle pulse from scan-out after its last visible line
write_en  out  1  frame buffer write strobe
write_pixel_num  out  17  {bank, y[7:0], x[7:0]} write address
write_pixel_color  out  COLOR_W  write data
read_bank  out  1  bank the scan-out side must read
frame_done  out  1  one-cycle pulse when a bank swap occurs
frame_error  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset values: state=IDLE, x=0, y=0, read_bank=0, write_en=0, write_pixel_num=0, write_pixel_color=0, frame_done=0, frame_error=0. Reset mid-frame discards the partial frame; the bank contents are left as they are.
- Acceptance: a beat is accepted when pix_valid && pix_ready.
- pix_ready is 1 in IDLE and FILL and 0 in WAIT_SWAP. It is a registered or state-decoded signal, never combinationally dependent on pix_valid.
- Write latency is 1 cycle. The cycle after an accepted beat that is written: write_en=1, write_pixel_num={~read_bank, y, x}, write_pixel_color=registered pix_color. write_en=0 in all other cycles.
- The write bank is always ~read_bank as sampled at the acceptance cycle.
- IDLE:
  - Accepted beat with pix_sof=0: discarded (no write); stay in IDLE.
  - Accepted beat with pix_sof=1: written at (0,0); set x=1, y=0; go to FILL.
- FILL:
  - Accepted beat with pix_sof=0: written at (x,y). x increments; at x=SCREEN_W-1, x wraps to 0 and y increments.
  - Accepted beat with pix_sof=1: frame_error pulses, the beat is written at (0,0), and counters restart at x=1, y=0.
  - The write of (255,239) moves the state to WAIT_SWAP in the same cycle.
- WAIT_SWAP:
  - No beats are accepted.
  - On vga_frame_end: read_bank toggles, frame_done pulses, x=y=0, state goes to IDLE; all take effect the next cycle.
- vga_frame_end in IDLE or FILL is ignored: no swap, and the display repeats the previous bank.
- Simultaneous events:
  - vga_frame_end in the same cycle as the final FILL write: ignored. The swap waits for the next pulse, because WAIT_SWAP is entered only after that cycle.
  - pix_sof at the final pixel position: treated as a restart (frame_error), not as frame completion.
- The counter widths are 8 bits each. y never exceeds SCREEN_H-1; reaching y=SCREEN_H is unreachable by construction and is checked by an assertion.

Decomposition:
- Shared package fb_pkg holds:
  - SCREEN_W, SCREEN_H, COLOR_W
  - PIXEL_NUM_W=16
  - typedef pixel_num_t (logic [15:0])
  - typedef color_t (logic [COLOR_W-1:0])
  - enum fbw_state_t {IDLE, FILL, WAIT_SWAP}
- The display reader and this block import the same package.
- One natural sub-module, raster_counter: x/y counter with clear, advance, and last-pixel flag. It is reusable by the reader.

Test Plan:
- Reset, then stream 61440 beats (first with pix_sof=1, color = index mod 64), then one vga_frame_end pulse. Required: 61440 writes with addresses 0x10000..0x1EFFF in order; pix_ready=0 after the last; read_bank 0->1; one frame_done pulse.
- 5 beats with pix_sof=0 before the first pix_sof -> no write_en; the sof beat is written at 0x10000.
- pix_sof asserted at beat 1000 of a frame -> frame_error pulses once; that beat is written at 0x10000; the frame completes after 61440 further beats.
- vga_frame_end pulsed during FILL and in the cycle of the final write -> read_bank unchanged; swap occurs only on the next pulse in WAIT_SWAP.
- pix_valid toggled randomly (about 50% duty) across two frames -> write addresses stay contiguous with no gaps or duplicates; the second frame is written to bank 0 (0x00000..0x0EFFF).
- reset asserted mid-FILL at pixel 30000 -> the next cycle shows IDLE, read_bank=0 and pix_ready=1; the following sof frame restarts at address 0x10000.
